cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor.
- Generalises the fixed 8-bit gate-level CLA to any WIDTH split into lookahead groups of GROUP bits.
- Adds valid/ready flow control, a subtract mode and status flags.
- Sits between operand registers and the ALU result mux. Accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a multiple of GROUP and at least 4.
- GROUP, 4, bits per lookahead group. Each group yields a generate/propagate pair.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat is valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used only when sub=0
- sub  in  1  1 selects a - b, 0 selects a + b + cin
- out_valid  out  1  result beat is valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready rises on the first cycle after release. Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Operand conditioning: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage 1 (registered on accept):
  - per-bit g_i = a_i & b_eff_i and p_i = a_i ^ b_eff_i;
  - per-group G_k and P_k via GROUP-bit lookahead;
  - stores p, g, G, P, c0, a_msb, b_eff_msb and s1_valid.
- Stage 2 (registered):
  - group carries C_{k+1} = G_k | P_k & C_k, computed as a flat lookahead across groups (no ripple);
  - in-group carries from local g/p;
  - sum_i = p_i ^ c_i; cout = carry out of bit WIDTH-1;
  - ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb);
  - zero = ~|sum.
- Latency: an accepted beat appears at out_valid exactly 2 cycles later when there is no stall.
- Flow control (pipeline-register style, no skid buffer):
  - en2 = !s2_valid | out_ready;
  - en1 = !s1_valid | en2;
  - in_ready = en1, combinational, depending on out_ready and internal valids only, never on in_valid.
  - Accept occurs when in_valid & in_ready; s1 loads operands. When en1 and no accept, s1_valid clears (bubble).
  - When en2, stage 2 loads from s1, and s2_valid <= s1_valid.
  - Bubbles collapse: a stalled output does not block stage 1 while s1 is empty.
- Output stability: while out_valid=1 and out_ready=0, sum, cout, ovf and zero hold constant. The stage-1 beat also holds.
- Throughput: 1 result per cycle with out_ready held high. Maximum 2 beats in flight.
- Simultaneous events: out_ready and in_valid high on a full pipe in the same cycle gives accept, shift and emit all at once, with no loss or duplication.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only on cout.
- Elaboration check: error if WIDTH % GROUP != 0.

Test Plan:
- WIDTH=8, GROUP=4, out_ready=1: a=0x3C, b=0x0F, cin=1, sub=0 -> 2 cycles later sum=0x4C, cout=0, ovf=0, zero=0.
- Full-length carry chain: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, zero=1, ovf=0. Separately, a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1, cout=0.
- Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1, cout=1.
- Back-pressure:
  - stream 4 beats, hold out_ready=0 from cycle 3;
  - in_ready drops after 2 beats are in flight, outputs hold stable;
  - release out_ready -> remaining results emerge in order with no loss or duplication.
- Bubble collapse: a single beat is issued, out_ready=0 -> in_ready stays 1 the next cycle and a second beat is accepted. A third beat is refused until out_ready=1.
- Async reset: assert rst_n low mid-stream between clock edges -> out_valid=0 and all flags 0 immediately. After release, no stale result appears. A WIDTH=16 GROUP=4 regression of 1000 random ops matches the golden model.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor with status flags.
// Latency: 2 cycles from accept to out_valid when not stalled; one beat per cycle throughput.
// Backpressure: pipeline-register valid/ready, no skid; in_ready depends only on out_ready and internal valids.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, cin, sub (operand beat);
//        out_valid/out_ready, sum, cout, ovf, zero (result beat).
module cla_pipe_adder #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_group
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end
  if (WIDTH < 4) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be at least 4");
  end

  // Stage-1 state
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NG-1:0]    r_G;
  logic [NG-1:0]    r_P;
  logic             r_c0;
  logic             r_a_msb;
  logic             r_b_msb;

  // Stage-2 state
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  // Holds in_ready low until the first clock edge after reset release.
  logic             r_live;

  logic             w_en1;
  logic             w_en2;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [NG-1:0]    w_G;
  logic [NG-1:0]    w_P;
  logic [NG:0]      w_cg;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_zero;

  // Flow control
  assign w_en2    = !r_s2_valid | out_ready;
  assign w_en1    = !r_s1_valid | w_en2;
  assign in_ready = w_en1 & r_live;
  assign w_accept = in_valid & in_ready;

  // Operand conditioning: subtract is a + ~b + 1.
  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub | cin;
  assign w_g     = a & w_b_eff;
  assign w_p     = a ^ w_b_eff;

  // Group generate/propagate, folded from the group LSB upwards.
  always_comb begin : grp_gp
    logic gacc;
    logic pacc;
    w_G = '0;
    w_P = '0;
    for (int k = 0; k < NG; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        gacc = w_g[k*GROUP+j] | (w_p[k*GROUP+j] & gacc);
        pacc = pacc & w_p[k*GROUP+j];
      end
      w_G[k] = gacc;
      w_P[k] = pacc;
    end
  end

  // Group carries as a flat sum of products: C[k+1] = OR_j (G[j] & P[j+1..k]) | (P[0..k] & c0).
  always_comb begin : grp_carry
    logic acc;
    logic prod;
    w_cg    = '0;
    w_cg[0] = r_c0;
    for (int k = 0; k < NG; k++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc  = acc | (prod & r_G[j]);
        prod = prod & r_P[j];
      end
      w_cg[k+1] = acc | (prod & r_c0);
    end
  end

  // In-group carries from the local g/p, seeded by each group's carry-in.
  always_comb begin : grp_sum
    logic c;
    w_sum = '0;
    for (int k = 0; k < NG; k++) begin
      c = w_cg[k];
      for (int j = 0; j < GROUP; j++) begin
        w_sum[k*GROUP+j] = r_p[k*GROUP+j] ^ c;
        c = r_g[k*GROUP+j] | (r_p[k*GROUP+j] & c);
      end
    end
  end

  assign w_cout = w_cg[NG];
  assign w_ovf  = (r_a_msb == r_b_msb) & (w_sum[WIDTH-1] != r_a_msb);
  assign w_zero = ~|w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_G        <= '0;
      r_P        <= '0;
      r_c0       <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else if (w_en1) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_p     <= w_p;
        r_g     <= w_g;
        r_G     <= w_G;
        r_P     <= w_P;
        r_c0    <= w_c0;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= w_b_eff[WIDTH-1];
      end
    end
  end

  // Result registers only load on a real beat, so a bubble never disturbs the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_en2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and random checks of cla_pipe_adder at WIDTH=8 and WIDTH=16.
// Latency: results expected 2 cycles after accept with out_ready high.
// Backpressure: out_ready is driven per step; results are matched in order against an arithmetic model.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8, zero8;
  logic [7:0] a8, b8, sum8;
  logic        iv16, ir16, ov16, or16, cin16, sub16, cout16, ovf16, zero16;
  logic [15:0] a16, b16, sum16;

  cla_pipe_adder #(.WIDTH(8), .GROUP(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  // Observed result packed as {zero, ovf, cout, sum[15:0]}.
  logic [18:0] obs8, obs16;
  assign obs8  = {zero8, ovf8, cout8, 8'h00, sum8};
  assign obs16 = {zero16, ovf16, cout16, sum16};

  int total = 0;
  int bad   = 0;
  logic [18:0] q8[$];
  logic [18:0] q16[$];
  int pops8 = 0;
  int pops16 = 0;
  int pushed16 = 0;

  // Reference: plain integer arithmetic on a w-bit machine.
  function automatic logic [18:0] model(input int w, input logic [15:0] xa, input logic [15:0] xb,
                                        input logic xc, input logic xs);
    longint m, half, ua, ub, full, sa, sb, res;
    logic [15:0] s;
    logic co, ov, z;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(xa);
    ub   = longint'(xb);
    full = xs ? (ua - ub + m) : (ua + ub + longint'(xc));
    s    = 16'(full % m);
    co   = (full >= m);
    z    = ((full % m) == 0);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    res  = xs ? (sa - sb) : (sa + sb + longint'(xc));
    ov   = (res >= half) || (res < -half);
    return {z, ov, co, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step on the 8-bit instance: drive at negedge, then score the upcoming edge's handshakes.
  task automatic cyc8(input logic iv, input logic [7:0] xa, input logic [7:0] xb,
                      input logic xc, input logic xs, input logic xr);
    @(negedge clk);
    iv8 = iv; a8 = xa; b8 = xb; cin8 = xc; sub8 = xs; or8 = xr;
    #1;
    if (ov8 && or8) begin
      if (q8.size() == 0) check("spurious8", 32'(ov8), 32'd0);
      else begin
        check("res8", 32'(obs8), 32'(q8.pop_front()));
        pops8++;
      end
    end
    if (iv8 && ir8) q8.push_back(model(8, {8'h00, xa}, {8'h00, xb}, xc, xs));
  endtask

  task automatic cyc16(input logic iv, input logic [15:0] xa, input logic [15:0] xb,
                       input logic xc, input logic xs, input logic xr);
    @(negedge clk);
    iv16 = iv; a16 = xa; b16 = xb; cin16 = xc; sub16 = xs; or16 = xr;
    #1;
    if (ov16 && !or16 && q16.size() != 0) check("hold16", 32'(obs16), 32'(q16[0]));
    if (ov16 && or16) begin
      if (q16.size() == 0) check("spurious16", 32'(ov16), 32'd0);
      else begin
        check("res16", 32'(obs16), 32'(q16.pop_front()));
        pops16++;
      end
    end
    if (iv16 && ir16) begin
      q16.push_back(model(16, xa, xb, xc, xs));
      pushed16++;
    end
  endtask

  task automatic dir8(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                      input logic xc, input logic xs, input logic [18:0] exp);
    cyc8(1'b1, xa, xb, xc, xs, 1'b1);
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check({tag, "_lat1"}, 32'(ov8), 32'd0);
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check(tag, 32'({ov8, obs8}), 32'({1'b1, exp}));
  endtask

  logic [7:0] ba[7];
  logic [7:0] bb[7];
  logic       bc[7];
  logic       bs[7];
  int         p0;

  initial begin
    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 0;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 0;
    for (int i = 0; i < 7; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom);
      bc[i] = 1'($urandom); bs[i] = 1'($urandom);
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ov8", 32'(ov8), 32'd0);
    check("rst_flags8", 32'(obs8), 32'd0);
    check("rst_ir8", 32'(ir8), 32'd0);
    check("rst_ov16", 32'({ov16, obs16}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ir_at_release", 32'(ir8), 32'd0);
    @(negedge clk);
    #1;
    check("ir_after_release", 32'(ir8), 32'd1);

    // Directed arithmetic
    dir8("add_3c_0f", 8'h3C, 8'h0F, 1'b1, 1'b0, 19'h0004C);
    dir8("carry_ff",  8'hFF, 8'h00, 1'b1, 1'b0, 19'h50000);
    dir8("ovf_7f",    8'h7F, 8'h01, 1'b0, 1'b0, 19'h20080);
    dir8("sub_5_7",   8'h05, 8'h07, 1'b0, 1'b1, 19'h000FE);
    dir8("sub_80_1",  8'h80, 8'h01, 1'b0, 1'b1, 19'h3007F);

    // Back-pressure: 4 beats, out_ready low from the third cycle
    p0 = pops8;
    cyc8(1'b1, ba[0], bb[0], bc[0], bs[0], 1'b1);
    cyc8(1'b1, ba[1], bb[1], bc[1], bs[1], 1'b1);
    cyc8(1'b1, ba[2], bb[2], bc[2], bs[2], 1'b0);
    check("bp_ir_c3", 32'(ir8), 32'd0);
    check("bp_hold_c3", 32'({ov8, obs8}), 32'({1'b1, q8[0]}));
    cyc8(1'b1, ba[2], bb[2], bc[2], bs[2], 1'b0);
    check("bp_ir_c4", 32'(ir8), 32'd0);
    check("bp_hold_c4", 32'({ov8, obs8}), 32'({1'b1, q8[0]}));
    cyc8(1'b1, ba[2], bb[2], bc[2], bs[2], 1'b1);
    check("bp_ir_c5", 32'(ir8), 32'd1);
    cyc8(1'b1, ba[3], bb[3], bc[3], bs[3], 1'b1);
    repeat (3) cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("bp_pops", 32'(pops8 - p0), 32'd4);
    check("bp_empty", 32'(q8.size()), 32'd0);

    // Bubble collapse
    p0 = pops8;
    cyc8(1'b1, ba[4], bb[4], bc[4], bs[4], 1'b0);
    cyc8(1'b1, ba[5], bb[5], bc[5], bs[5], 1'b0);
    check("bub_ir", 32'(ir8), 32'd1);
    cyc8(1'b1, ba[6], bb[6], bc[6], bs[6], 1'b0);
    check("bub_refuse", 32'(ir8), 32'd0);
    check("bub_hold", 32'({ov8, obs8}), 32'({1'b1, q8[0]}));
    cyc8(1'b1, ba[6], bb[6], bc[6], bs[6], 1'b0);
    check("bub_refuse2", 32'(ir8), 32'd0);
    cyc8(1'b1, ba[6], bb[6], bc[6], bs[6], 1'b1);
    check("bub_accept", 32'(ir8), 32'd1);
    repeat (4) cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("bub_pops", 32'(pops8 - p0), 32'd3);
    check("bub_empty", 32'(q8.size()), 32'd0);

    // Asynchronous reset mid-stream
    cyc8(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    cyc8(1'b1, ba[0], bb[0], bc[0], bs[0], 1'b1);
    cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("pre_rst_ov", 32'({ov8, zero8, cout8}), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(ov8), 32'd0);
    check("arst_flags", 32'(obs8), 32'd0);
    check("arst_ir", 32'(ir8), 32'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      check("no_stale", 32'(ov8), 32'd0);
    end

    // Random regression at WIDTH=16, random valid and ready
    for (int cy = 0; cy < 6000 && pushed16 < 1000; cy++) begin
      cyc16($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0);
    end
    check("rand_count", 32'(pushed16), 32'd1000);
    repeat (10) cyc16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("rand_pops", 32'(pops16), 32'(pushed16));
    check("rand_empty", 32'(q16.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
